// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the 7-segment capture path.
//   - Active-low segment patterns (abcdefg) for digits 0-9 and the blank pattern
//   - Active-low digit-select codes for the four display positions plus "none"
//   - Conversion FSM state type
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] SEL_THOU  = 4'b0111;
   localparam logic [3:0] SEL_HUND  = 4'b1011;
   localparam logic [3:0] SEL_TENS  = 4'b1101;
   localparam logic [3:0] SEL_ONES  = 4'b1110;
   localparam logic [3:0] SEL_NONE  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

endpackage

// File: rtl/seg_pattern_decoder.sv
// -----------------------------------------------------------------------------
// seg_pattern_decoder
// Combinational decode of an active-low abcdefg segment pattern to a BCD digit.
// Configuration macro: SEVEN_SEG_CAPTURE_BLANK_ZERO_EN -- when defined, the
// all-off pattern decodes as a valid 0 (leading-zero-blanked displays).
// Ports:
//   i_pattern  in   7  segment pattern, active low
//   o_valid    out  1  pattern is a recognised digit
//   o_digit    out  4  decoded digit (0 when invalid)
// -----------------------------------------------------------------------------
module seg_pattern_decoder
   import seg_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic       o_valid,
   output logic [3:0] o_digit
);

   always_comb begin
      o_valid = 1'b1;
      o_digit = '0;
      case (i_pattern)
         SEG_0:     o_digit = 4'd0;
         SEG_1:     o_digit = 4'd1;
         SEG_2:     o_digit = 4'd2;
         SEG_3:     o_digit = 4'd3;
         SEG_4:     o_digit = 4'd4;
         SEG_5:     o_digit = 4'd5;
         SEG_6:     o_digit = 4'd6;
         SEG_7:     o_digit = 4'd7;
         SEG_8:     o_digit = 4'd8;
         SEG_9:     o_digit = 4'd9;
`ifdef SEVEN_SEG_CAPTURE_BLANK_ZERO_EN
         SEG_BLANK: o_digit = 4'd0;
`endif
         default:   o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
// Passive monitor on a multiplexed 7-segment bus. Waits for each digit to be
// stable, decodes it, assembles a 4-digit frame and converts it to binary.
// Configuration macro: SEVEN_SEG_CAPTURE_BLANK_ZERO_EN (see seg_pattern_decoder).
// Parameters:
//   SETTLE_CYCLES   identical bus cycles required before sampling (>= 2)
//   TIMEOUT_CYCLES  sample-free cycles before a partial frame is dropped
// Ports:
//   clk            in   1   system clock
//   rst            in   1   asynchronous active-high reset
//   segments       in   7   observed segments abcdefg, active low
//   digit_sel      in   4   observed digit enables, active low
//   value          out  14  last good frame, binary
//   digits_bcd     out  16  last good frame, BCD {thou,hund,tens,ones}
//   value_valid    out  1   pulse when value/digits_bcd update
//   decode_err     out  1   pulse when a completed frame held a bad digit
//   frame_timeout  out  1   high from timeout until the next sample
// -----------------------------------------------------------------------------
module seven_seg_capture
   import seg_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 200000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  segments,
   input  logic [3:0]  digit_sel,
   output logic [13:0] value,
   output logic [15:0] digits_bcd,
   output logic        value_valid,
   output logic        decode_err,
   output logic        frame_timeout
);

   localparam int unsigned CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_PRE = CW'(SETTLE_CYCLES - 2);
   localparam logic [TW-1:0] GAP_MAX = TW'(TIMEOUT_CYCLES - 1);

   // ---------------- stability tracking ----------------
   logic [10:0]   r_prev;
   logic [CW-1:0] r_cnt;
   logic          w_same;
   logic          w_legal;
   logic          w_illegal;
   logic [1:0]    w_slot;
   logic          w_sample;

   always_comb begin
      w_legal   = 1'b1;
      w_illegal = 1'b0;
      w_slot    = 2'd0;
      case (digit_sel)
         SEL_THOU: w_slot = 2'd3;
         SEL_HUND: w_slot = 2'd2;
         SEL_TENS: w_slot = 2'd1;
         SEL_ONES: w_slot = 2'd0;
         SEL_NONE: w_legal = 1'b0;
         default: begin
            w_legal   = 1'b0;
            w_illegal = 1'b1;
         end
      endcase
   end

   assign w_same = ({digit_sel, segments} == r_prev);
   // One sample per dwell: fire on the step that takes the counter to its
   // saturation value, so a longer dwell never re-samples.
   assign w_sample = w_legal && w_same && (r_cnt == CNT_PRE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_prev <= {digit_sel, segments};
         if (w_illegal || !w_same)
            r_cnt <= '0;
         else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   // ---------------- digit decode ----------------
   logic       w_dec_valid;
   logic [3:0] w_dec_digit;

   seg_pattern_decoder u_dec (
      .i_pattern (segments),
      .o_valid   (w_dec_valid),
      .o_digit   (w_dec_digit)
   );

   // ---------------- frame assembly ----------------
   logic [15:0]   r_digits;
   logic [3:0]    r_mask;
   logic          r_err;
   logic [TW-1:0] r_gap;
   logic [15:0]   w_frame_digits;
   logic [3:0]    w_mask_new;
   logic          w_frame_err;
   logic          w_frame_done;
   logic          w_frame_good;

   always_comb begin
      w_frame_digits = r_digits;
      w_frame_digits[{w_slot, 2'b00} +: 4] = w_dec_digit;
   end

   assign w_mask_new   = r_mask | (4'b0001 << w_slot);
   assign w_frame_err  = r_err | ~w_dec_valid;
   assign w_frame_done = w_sample && (w_mask_new == 4'hF);
   assign w_frame_good = w_frame_done && !w_frame_err;

   // A completing sample always clears the gap counter, so a timeout in the
   // same cycle is suppressed without extra logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_digits      <= '0;
         r_mask        <= '0;
         r_err         <= 1'b0;
         r_gap         <= '0;
         frame_timeout <= 1'b0;
         decode_err    <= 1'b0;
      end else begin
         decode_err <= w_frame_done && w_frame_err;
         if (w_sample) begin
            r_digits      <= w_frame_digits;
            r_gap         <= '0;
            frame_timeout <= 1'b0;
            if (w_frame_done) begin
               r_mask <= '0;
               r_err  <= 1'b0;
            end else begin
               r_mask <= w_mask_new;
               r_err  <= w_frame_err;
            end
         end else if (r_gap == GAP_MAX) begin
            r_gap         <= '0;
            r_mask        <= '0;
            r_err         <= 1'b0;
            frame_timeout <= 1'b1;
         end else begin
            r_gap <= r_gap + 1'b1;
         end
      end
   end

   // ---------------- BCD -> binary conversion FSM ----------------
   state_t      r_state;
   logic [15:0] r_conv;
   logic [13:0] r_acc;
   logic [1:0]  r_step;
   logic [15:0] r_pend;
   logic        r_pend_valid;
   logic [3:0]  w_conv_digit;
   logic [13:0] w_acc_next;

   // Thousands first: step 0 selects bits [15:12].
   assign w_conv_digit = r_conv[{~r_step, 2'b00} +: 4];
   assign w_acc_next   = (r_acc << 3) + (r_acc << 1) + {10'd0, w_conv_digit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_conv       <= '0;
         r_acc        <= '0;
         r_step       <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         value        <= '0;
         digits_bcd   <= '0;
         value_valid  <= 1'b0;
      end else begin
         value_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               // A fresh completion supersedes any older pending frame.
               if (w_frame_good) begin
                  r_conv       <= w_frame_digits;
                  r_acc        <= '0;
                  r_step       <= '0;
                  r_pend_valid <= 1'b0;
                  r_state      <= CONV;
               end else if (r_pend_valid) begin
                  r_conv       <= r_pend;
                  r_acc        <= '0;
                  r_step       <= '0;
                  r_pend_valid <= 1'b0;
                  r_state      <= CONV;
               end
            end
            CONV: begin
               if (w_frame_good) begin
                  r_pend       <= w_frame_digits;
                  r_pend_valid <= 1'b1;
               end
               r_acc  <= w_acc_next;
               r_step <= r_step + 1'b1;
               if (r_step == 2'd3) begin
                  value       <= w_acc_next;
                  digits_bcd  <= r_conv;
                  value_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (w_frame_good) begin
                  r_pend       <= w_frame_digits;
                  r_pend_valid <= 1'b1;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
